// File: rtl/inv_sqrt_arbiter.sv
// Round-robin arbiter that shares one fastInvSqrt core between NUM_REQ requesters,
// with a watchdog that answers with an error response when the core stays silent.
module inv_sqrt_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int INT_WIDTH      = 12,
  parameter int FRACT_WIDTH    = 4,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int W    = INT_WIDTH + FRACT_WIDTH,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*W-1:0] req_data,
  output logic [NUM_REQ-1:0]   rsp_valid,
  input  logic [NUM_REQ-1:0]   rsp_ready,
  output logic [W-1:0]         rsp_data,
  output logic                 rsp_err,
  output logic [W-1:0]         core_data_in,
  output logic                 core_valid_in,
  input  logic                 core_ready_in,
  input  logic [W-1:0]         core_data_out,
  input  logic                 core_valid_out,
  output logic                 core_ready_out,
  output logic                 busy,
  output logic [ID_W-1:0]      grant_id
);

  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ID_W-1:0] ID_LAST = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          state, state_d;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant_q;
  logic [W-1:0]    operand_q;
  logic [W-1:0]    result_q;
  logic            err_q;
  logic [WD_W-1:0] wd_q;

  logic            pick_valid;
  logic [ID_W-1:0] pick_id;
  logic [ID_W-1:0] cand;

  // First set req_valid bit at or above rr_ptr, wrapping back to 0.
  // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(rr_ptr) + i >= NUM_REQ) ? ID_W'(int'(rr_ptr) + i - NUM_REQ)
                                           : ID_W'(int'(rr_ptr) + i);
      if (!pick_valid && req_valid[cand]) begin
        pick_valid = 1'b1;
        pick_id    = cand;
      end
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (pick_valid) state_d = S_ISSUE;
      S_ISSUE: if (core_ready_in) state_d = S_WAIT;
      S_WAIT:  if (core_valid_out || wd_q == WD_LAST) state_d = S_RESP;
      S_RESP:  if (rsp_ready[grant_q]) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (state == S_IDLE && pick_valid) req_ready[pick_id] = 1'b1;
    if (state == S_RESP) rsp_valid[grant_q] = 1'b1;
  end

  assign core_valid_in  = (state == S_ISSUE);
  assign core_data_in   = (state == S_ISSUE) ? operand_q : '0;
  assign core_ready_out = (state == S_WAIT);
  assign busy           = (state != S_IDLE);
  assign rsp_data       = result_q;
  assign rsp_err        = err_q;
  assign grant_id       = grant_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      grant_q   <= '0;
      operand_q <= '0;
      result_q  <= '0;
      err_q     <= 1'b0;
      wd_q      <= '0;
    end else begin
      state <= state_d;
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            operand_q <= req_data[int'(pick_id)*W +: W];
            grant_q   <= pick_id;
            rr_ptr    <= (pick_id == ID_LAST) ? '0 : pick_id + 1'b1;
          end
        end
        S_ISSUE: begin
          if (core_ready_in) wd_q <= '0;
        end
        S_WAIT: begin
          wd_q <= wd_q + 1'b1;
          // A core pulse on the final watchdog cycle still counts as a real answer.
          if (core_valid_out) begin
            result_q <= core_data_out;
            err_q    <= 1'b0;
          end else if (wd_q == WD_LAST) begin
            result_q <= '0;
            err_q    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_sqrt_arbiter.sv
// Bench for inv_sqrt_arbiter: fixed-latency core model plus a response scoreboard
// filled at each accepted request and drained at each completed response.
module tb_inv_sqrt_arbiter;

  localparam int NUM_REQ = 4;
  localparam int W       = 16;
  localparam int ID_W    = 2;
  localparam int TMO     = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*W-1:0] req_data;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [NUM_REQ-1:0]   rsp_ready;
  logic [W-1:0]         rsp_data;
  logic                 rsp_err;
  logic [W-1:0]         core_data_in;
  logic                 core_valid_in;
  logic                 core_ready_in;
  logic [W-1:0]         core_data_out;
  logic                 core_valid_out;
  logic                 core_ready_out;
  logic                 busy;
  logic [ID_W-1:0]      grant_id;

  int errors = 0;
  int checks = 0;
  int hs_count = 0;

  inv_sqrt_arbiter #(
    .NUM_REQ(NUM_REQ), .INT_WIDTH(12), .FRACT_WIDTH(4), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .core_data_in(core_data_in), .core_valid_in(core_valid_in), .core_ready_in(core_ready_in),
    .core_data_out(core_data_out), .core_valid_out(core_valid_out), .core_ready_out(core_ready_out),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // Q12.4 reference: round(16 / sqrt(x / 16)).
  function automatic logic [W-1:0] model_isqrt(input logic [W-1:0] x);
    real r;
    r = real'(x) / 16.0;
    return W'(int'(16.0 / $sqrt(r)));
  endfunction

  // Core model: answers lat_cfg cycles into WAIT, or never when never_pulse is set.
  int         lat_cfg = 5;
  bit         never_pulse = 1'b0;
  int         lat_cnt;
  logic [W-1:0] core_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt  <= 0;
      core_res <= '0;
    end else if (core_valid_in && core_ready_in) begin
      lat_cnt  <= never_pulse ? 0 : lat_cfg;
      core_res <= model_isqrt(core_data_in);
    end else if (lat_cnt > 0) begin
      lat_cnt <= lat_cnt - 1;
    end
  end
  assign core_valid_out = (lat_cnt == 1);
  assign core_data_out  = core_res;

  typedef struct {
    int          id;
    logic [W-1:0] data;
    logic        err;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (|(req_valid & req_ready)) begin
        checks++;
        if ($countones(req_ready) != 1 || (req_ready & ~req_valid) != '0) begin
          errors++;
          $display("FAIL req_ready_onehot: got %b with req_valid %b", req_ready, req_valid);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
          if (req_ready[i]) begin
            mon_e.id   = i;
            mon_e.err  = never_pulse;
            mon_e.data = never_pulse ? '0 : model_isqrt(req_data[i*W +: W]);
            sb.push_back(mon_e);
          end
        end
        hs_count++;
      end
      if (|rsp_valid) begin
        checks++;
        if ($countones(rsp_valid) != 1) begin
          errors++;
          $display("FAIL rsp_valid_onehot: got %b, required exactly one bit", rsp_valid);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
          if (rsp_valid[i] && rsp_ready[i]) begin
            checks++;
            if (sb.size() == 0) begin
              errors++;
              $display("FAIL rsp_unexpected: response on %0d with no outstanding request", i);
            end else begin
              mon_e = sb.pop_front();
              if (i != mon_e.id || rsp_data !== mon_e.data || rsp_err !== mon_e.err) begin
                errors++;
                $display("FAIL rsp_content: got id=%0d data=%h err=%b, required id=%0d data=%h err=%b",
                         i, rsp_data, rsp_err, mon_e.id, mon_e.data, mon_e.err);
              end
            end
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    req_valid = '0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sb.delete();
  endtask

  // Waits for a request handshake, then steps past the accepting edge.
  task automatic wait_accept(input string tag);
    bit ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (|(req_valid & req_ready)) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tick();
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_accept: no handshake within 20 cycles", tag);
    end
  endtask

  task automatic wait_done(input string tag);
    bit ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (sb.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_done: %0d responses outstanding, busy=%b after 100 cycles", tag, sb.size(), busy);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks += 4;
    if ({req_ready, rsp_valid, rsp_err, core_valid_in, core_ready_out, busy} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: req_ready=%b rsp_valid=%b err=%b cvi=%b cro=%b busy=%b, required 0",
               req_ready, rsp_valid, rsp_err, core_valid_in, core_ready_out, busy);
    end
    if (rsp_data !== '0) begin
      errors++; $display("FAIL reset_rsp_data: got %h required 0", rsp_data);
    end
    if (core_data_in !== '0) begin
      errors++; $display("FAIL reset_core_data_in: got %h required 0", core_data_in);
    end
    if (grant_id !== '0) begin
      errors++; $display("FAIL reset_grant_id: got %0d required 0", grant_id);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    int lat = 0;
    req_data[0*W +: W] = 16'h0040;
    req_valid = 4'b0001;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL single_req_ready: got %b required 0001", req_ready);
    end
    tick();
    req_valid = 4'b1110;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid != '0) break;
      checks++;
      if (req_ready !== '0) begin
        errors++; $display("FAIL single_ready_busy: got %b required 0000 at cycle %0d", req_ready, lat);
      end
      tick();
    end
    checks++;
    if (lat != 7) begin
      errors++; $display("FAIL single_latency: got %0d cycles required 7", lat);
    end
    tick();
    req_valid = '0;
    wait_done("single");
  endtask

  task automatic test_round_robin;
    int  k = 0;
    bit  gid_pending = 1'b0;
    int  gid_exp = 0;
    logic [NUM_REQ-1:0] oh;
    apply_reset();
    req_data = {16'h0190, 16'h0010, 16'h0100, 16'h0040};
    req_valid = 4'b1111;
    for (int c = 0; c < 300 && k < 5; c++) begin
      @(negedge clk);
      if (gid_pending) begin
        checks++;
        if (grant_id !== ID_W'(gid_exp)) begin
          errors++; $display("FAIL rr_grant_id: got %0d required %0d", grant_id, gid_exp);
        end
        gid_pending = 1'b0;
      end
      if (|(req_valid & req_ready)) begin
        oh = '0;
        oh[k % NUM_REQ] = 1'b1;
        checks++;
        if (req_ready !== oh) begin
          errors++; $display("FAIL rr_order: grant %0d got %b required %b", k, req_ready, oh);
        end
        gid_exp = k % NUM_REQ;
        gid_pending = 1'b1;
        k++;
      end
      tick();
    end
    req_valid = '0;
    if (gid_pending) begin
      @(negedge clk);
      checks++;
      if (grant_id !== ID_W'(gid_exp)) begin
        errors++; $display("FAIL rr_grant_id: got %0d required %0d", grant_id, gid_exp);
      end
    end
    checks++;
    if (k != 5) begin
      errors++; $display("FAIL rr_count: got %0d grants required 5", k);
    end
    wait_done("rr");
  endtask

  task automatic test_backpressure;
    apply_reset();
    rsp_ready = 4'b1011;
    req_data[2*W +: W] = 16'h0100;
    req_valid = 4'b0100;
    wait_accept("bp");
    req_data[0*W +: W] = 16'h0190;
    req_valid = 4'b0001;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (rsp_valid != '0) break;
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (rsp_valid !== 4'b0100 || rsp_data !== 16'h0004 || rsp_err !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d got valid=%b data=%h err=%b required 0100/0004/0",
                 i, rsp_valid, rsp_data, rsp_err);
      end
      checks++;
      if (req_ready !== '0 || grant_id !== 2'd2) begin
        errors++;
        $display("FAIL bp_no_grant: cycle %0d got req_ready=%b grant_id=%0d required 0000/2",
                 i, req_ready, grant_id);
      end
      tick();
    end
    rsp_ready = '1;
    wait_accept("bp_next");
    req_valid = '0;
    checks++;
    if (grant_id !== 2'd0) begin
      errors++; $display("FAIL bp_next_grant: got %0d required 0", grant_id);
    end
    wait_done("bp");
  endtask

  task automatic test_core_stall;
    apply_reset();
    core_ready_in = 1'b0;
    req_data[1*W +: W] = 16'h0010;
    req_valid = 4'b0010;
    wait_accept("stall");
    req_valid = '0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      checks++;
      if (core_valid_in !== 1'b1 || core_data_in !== 16'h0010) begin
        errors++;
        $display("FAIL stall_hold: cycle %0d got cvi=%b data=%h required 1/0010", i, core_valid_in, core_data_in);
      end
      tick();
    end
    core_ready_in = 1'b1;
    @(negedge clk);
    checks++;
    if (core_valid_in !== 1'b1) begin
      errors++; $display("FAIL stall_handshake: got cvi=%b required 1", core_valid_in);
    end
    tick();
    @(negedge clk);
    checks++;
    if (core_valid_in !== 1'b0 || core_ready_out !== 1'b1) begin
      errors++;
      $display("FAIL stall_drop: got cvi=%b cro=%b required 0/1", core_valid_in, core_ready_out);
    end
    wait_done("stall");
  endtask

  task automatic run_timeout(input string tag, input int req, input logic err_exp);
    int wc = 0;
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    oh[req] = 1'b1;
    req_data[req*W +: W] = 16'h0040;
    req_valid = oh;
    wait_accept(tag);
    req_valid = '0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (rsp_valid != '0) break;
      if (core_ready_out) wc++;
      tick();
    end
    checks++;
    if (wc != TMO) begin
      errors++; $display("FAIL %s_wait_cycles: got %0d required %0d", tag, wc, TMO);
    end
    checks++;
    if (rsp_valid !== oh || rsp_err !== err_exp || rsp_data !== (err_exp ? 16'h0000 : 16'h0008)) begin
      errors++;
      $display("FAIL %s_rsp: got valid=%b err=%b data=%h required %b/%b/%h", tag, rsp_valid, rsp_err,
               rsp_data, oh, err_exp, err_exp ? 16'h0000 : 16'h0008);
    end
    wait_done(tag);
  endtask

  task automatic test_timeout;
    apply_reset();
    never_pulse = 1'b1;
    run_timeout("timeout", 3, 1'b1);
    never_pulse = 1'b0;
    lat_cfg = TMO;
    run_timeout("late_pulse", 1, 1'b0);
    lat_cfg = 5;
  endtask

  task automatic test_reset_wait;
    apply_reset();
    req_data[3*W +: W] = 16'h0100;
    req_valid = 4'b1000;
    wait_accept("rstw");
    req_valid = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (core_ready_out) break;
      tick();
    end
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_err, core_valid_in, core_ready_out, busy} !== '0 ||
        rsp_data !== '0 || core_data_in !== '0 || grant_id !== '0) begin
      errors++;
      $display("FAIL rstw_outputs: rsp_valid=%b cro=%b busy=%b grant_id=%0d rsp_data=%h, required all 0",
               rsp_valid, core_ready_out, busy, grant_id, rsp_data);
    end
    tick();
    rst_n = 1'b1;
    sb.delete();
    req_data[0*W +: W] = 16'h0040;
    req_valid = 4'b1001;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL rstw_priority: got %b required 0001", req_ready);
    end
    tick();
    req_valid = 4'b1000;
    wait_accept("rstw_second");
    req_valid = '0;
    wait_done("rstw");
  endtask

  initial begin
    rst_n         = 1'b0;
    req_valid     = '0;
    req_data      = '0;
    rsp_ready     = '1;
    core_ready_in = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_core_stall();
    test_timeout();
    test_reset_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

endmodule
